fifo_word_packer: RTL and testbench

// Read-side consumer of the 8-bit FIFO. Drains bytes through the FIFO's registered read

---
 rtl/fifo_word_packer_if.sv | 28 ++
 rtl/fifo_word_packer.sv | 126 ++++++++++++
 tb/tb_fifo_word_packer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between the FIFO read port, the packer and the word consumer.
// The packer drives the master side; the FIFO/consumer pair sits on the slave side.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  localparam int CW = $clog2(PACK) + 1;

  logic                       fifo_empty;
  logic [DATA_WIDTH-1:0]      fifo_rd_data;
  logic                       rd_enb;
  logic                       flush_req;
  logic [DATA_WIDTH*PACK-1:0] m_data;
  logic [CW-1:0]              m_bytes;
  logic                       m_valid;
  logic                       m_ready;
  logic                       busy;

  modport master (
    input  fifo_empty, fifo_rd_data, flush_req, m_ready,
    output rd_enb, m_data, m_bytes, m_valid, busy
  );

  modport slave (
    output fifo_empty, fifo_rd_data, flush_req, m_ready,
    input  rd_enb, m_data, m_bytes, m_valid, busy
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains bytes from a registered-read FIFO and packs PACK of them little-endian into
// one output word; partial words leave on an explicit flush or after an idle timeout.
module fifo_word_packer_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rd_clk,
  input  logic                  rstn,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] q_q;

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn)     q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                rd_clk,
  input  logic                rstn,
  fifo_word_packer_if.master  bus
);
  localparam int CW = $clog2(PACK) + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                           state_q;
  logic [CW-1:0]                    cnt_q;
  logic                             pend_q;
  logic [IW-1:0]                    idle_q;
  logic                             flush_pend_q;
  logic                             m_valid_q;
  logic [PACK-1:0][DATA_WIDTH-1:0]  m_data_q;
  logic [CW-1:0]                    m_bytes_q;

  logic [PACK-1:0][DATA_WIDTH-1:0]  asm_w;
  logic [PACK-1:0][DATA_WIDTH-1:0]  word_d;
  logic [CW:0]                      occ;
  logic full, timeout, flush_fire, want, out_free, load, rd_enb;

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    fifo_word_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .rd_clk (rd_clk),
      .rstn   (rstn),
      .we_i   (pend_q && (cnt_q == CW'(i))),
      .d_i    (bus.fifo_rd_data),
      .q_o    (asm_w[i])
    );
  end

  // Bytes captured plus the one still in flight bound the next read.
  assign occ        = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
  assign full       = (cnt_q == CW'(PACK));
  assign timeout    = (idle_q == IW'(TIMEOUT));
  assign flush_fire = (flush_pend_q || timeout) && (cnt_q != '0) && !pend_q;
  assign want       = full || flush_fire;
  assign out_free   = !m_valid_q || bus.m_ready;
  assign load       = want && out_free;
  assign rd_enb     = rstn && (state_q == FILL) && !bus.fifo_empty && !flush_pend_q
                      && (occ < (CW+1)'(PACK));

  always_comb begin
    word_d = '0;
    for (int i = 0; i < PACK; i++)
      if (CW'(i) < cnt_q) word_d[i] = asm_w[i];
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      idle_q       <= '0;
      flush_pend_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_bytes_q    <= '0;
    end else begin
      pend_q <= rd_enb;

      // Capture and load never coincide: load needs pend==0 or a full word.
      if (load)        cnt_q <= '0;
      else if (pend_q) cnt_q <= cnt_q + CW'(1);

      if (load || pend_q || cnt_q == '0)
        idle_q <= '0;
      else if (bus.fifo_empty && state_q == FILL && !timeout)
        idle_q <= idle_q + IW'(1);

      if (flush_pend_q) begin
        if (load || (cnt_q == '0 && !pend_q)) flush_pend_q <= 1'b0;
      end else if (bus.flush_req) begin
        flush_pend_q <= 1'b1;
      end

      case (state_q)
        FILL:    if (want && !out_free) state_q <= HOLD;
        HOLD:    if (load)              state_q <= FILL;
        default:                        state_q <= FILL;
      endcase

      if (load) begin
        m_data_q  <= word_d;
        m_bytes_q <= cnt_q;
        m_valid_q <= 1'b1;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rd_enb  = rd_enb;
  assign bus.m_data  = m_data_q;
  assign bus.m_bytes = m_bytes_q;
  assign bus.m_valid = m_valid_q;
  assign bus.busy    = (cnt_q != '0) || pend_q || m_valid_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench: a queue-based FIFO feeds the packer; a byte-stream scoreboard checks every
// accepted word, plus literal expectations for the directed scenarios.
module tb_fifo_word_packer;
  localparam int DW = 8, PK = 4, TO = 15, CW = $clog2(PK) + 1;

  logic rd_clk = 1'b0;
  logic rstn   = 1'b0;

  fifo_word_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();
  fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(TO)) dut (
    .rd_clk (rd_clk),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  int n_err = 0, n_chk = 0, n_reads = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] log_d[$];
  int          log_b[$];
  logic        prev_v, prev_acc;
  logic [31:0] prev_d;
  logic [CW-1:0] prev_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: check at negedge, account for the handshakes, then drive after posedge.
  task automatic step();
    bit rd_fire, acc;
    logic [7:0] rd_byte;
    rd_byte = '0;
    @(negedge rd_clk);
    chk("busy", bus.busy, (exp_q.size() != 0) ? 64'd1 : 64'd0);
    chk("rd_enb_while_empty", bus.rd_enb & bus.fifo_empty, 0);
    if (prev_v && !prev_acc) begin
      chk("stall_valid", bus.m_valid, 1);
      chk("stall_data", bus.m_data, prev_d);
      chk("stall_bytes", bus.m_bytes, prev_b);
    end
    acc = bus.m_valid && bus.m_ready;
    if (bus.m_valid) begin
      chk("m_bytes_range", (bus.m_bytes >= 1 && bus.m_bytes <= PK) ? 64'd1 : 64'd0, 1);
      for (int i = 0; i < PK; i++)
        if (i >= int'(bus.m_bytes)) chk("unused_lane_zero", bus.m_data[8*i +: 8], 0);
    end
    if (acc) begin
      log_d.push_back(bus.m_data);
      log_b.push_back(int'(bus.m_bytes));
      if (exp_q.size() < int'(bus.m_bytes)) begin
        n_chk++; n_err++;
        $display("FAIL stream_len: word has %0d bytes, only %0d read", bus.m_bytes, exp_q.size());
      end else begin
        for (int i = 0; i < int'(bus.m_bytes); i++)
          chk("stream_byte", bus.m_data[8*i +: 8], exp_q.pop_front());
      end
    end
    rd_fire = bus.rd_enb && !bus.fifo_empty;
    if (rd_fire) begin
      rd_byte = fifo_q.pop_front();
      exp_q.push_back(rd_byte);
      n_reads++;
    end
    prev_v = bus.m_valid; prev_d = bus.m_data; prev_b = bus.m_bytes; prev_acc = acc;
    @(posedge rd_clk);
    #1;
    bus.fifo_rd_data = rd_fire ? rd_byte : 8'($urandom);
    bus.flush_req    = 1'b0;
    bus.fifo_empty   = (fifo_q.size() == 0);
  endtask

  task automatic wait_log(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (log_d.size() < n && k < bound) begin step(); k++; end
    if (log_d.size() < n) begin
      n_chk++; n_err++;
      $display("FAIL %s: timeout, got %0d words expected %0d", name, log_d.size(), n);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    fifo_q.delete(); exp_q.delete();
    bus.fifo_empty = 1'b1;
    prev_v = 1'b0; prev_acc = 1'b0;
    step();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_rd_enb", bus.rd_enb, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_bytes", bus.m_bytes, 0);
    rstn = 1'b1;
    log_d.delete(); log_b.delete();
  endtask

  initial begin
    int r0;
    bus.fifo_empty = 1'b1; bus.fifo_rd_data = '0; bus.flush_req = 1'b0; bus.m_ready = 1'b0;
    prev_v = 1'b0; prev_acc = 1'b0; prev_d = '0; prev_b = '0;
    #1;
    do_reset();

    // Reset mid-word discards captured bytes
    bus.m_ready = 1'b1;
    push(8'hA1); push(8'hA2);
    repeat (4) step();
    chk("t1_busy_midword", bus.busy, 1);
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    wait_log(1, 20, "t1_word");
    if (log_d.size() >= 1) begin
      chk("t1_data", log_d[0], 32'h13121110);
      chk("t1_bytes", log_b[0], 4);
    end
    log_d.delete(); log_b.delete();

    // Full word, valid for one cycle
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_log(1, 20, "t2_word");
    if (log_d.size() >= 1) begin
      chk("t2_data", log_d[0], 32'h44332211);
      chk("t2_bytes", log_b[0], 4);
    end
    step();
    chk("t2_valid_one_cycle", bus.m_valid, 0);
    log_d.delete(); log_b.delete();

    // Backpressure
    bus.m_ready = 1'b0;
    r0 = n_reads;
    for (int i = 0; i < 12; i++) push(8'(i));
    repeat (20) step();
    chk("t3_valid_held", bus.m_valid, 1);
    chk("t3_data_held", bus.m_data, 32'h03020100);
    chk("t3_reads_stop", n_reads - r0, 8);
    chk("t3_fifo_left", fifo_q.size(), 4);
    bus.m_ready = 1'b1;
    wait_log(3, 40, "t3_words");
    if (log_d.size() >= 3) begin
      chk("t3_w0", log_d[0], 32'h03020100);
      chk("t3_w1", log_d[1], 32'h07060504);
      chk("t3_w2", log_d[2], 32'h0B0A0908);
    end
    log_d.delete(); log_b.delete();

    // Idle timeout flushes a partial word
    push(8'hAA); push(8'hBB);
    repeat (18) step();
    chk("t4_not_early", log_d.size(), 0);
    wait_log(1, 20, "t4_word");
    if (log_d.size() >= 1) begin
      chk("t4_data", log_d[0], 32'h0000BBAA);
      chk("t4_bytes", log_b[0], 2);
    end
    log_d.delete(); log_b.delete();

    // Explicit flush, then flush with nothing held
    push(8'h01); push(8'h02); push(8'h03);
    repeat (5) step();
    bus.flush_req = 1'b1;
    wait_log(1, 5, "t5_word");
    if (log_d.size() >= 1) begin
      chk("t5_data", log_d[0], 32'h00030201);
      chk("t5_bytes", log_b[0], 3);
    end
    log_d.delete(); log_b.delete();
    repeat (3) step();
    bus.flush_req = 1'b1;
    repeat (30) step();
    chk("t5_no_empty_word", log_d.size(), 0);
    chk("t5_idle_valid", bus.m_valid, 0);

    // Random traffic against the stream scoreboard
    for (int c = 0; c < 10000; c++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 99) < 40) push(8'($urandom));
      bus.m_ready   = ($urandom_range(0, 99) < 60);
      bus.flush_req = ($urandom_range(0, 99) < 3);
      step();
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 300 && (fifo_q.size() != 0 || exp_q.size() != 0); c++) step();
    chk("drain_fifo", fifo_q.size(), 0);
    chk("drain_stream", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
